// File: rtl/ic_refill_ctrl.sv
// Instruction-cache line refill engine: fetches a 128-bit line as four 32-bit beats
// and keeps the most recently filled line in a reuse buffer for repeated misses.
module ic_refill_ctrl #(
  parameter bit BUF_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         irq,
  input  logic [27:0]  l2_addr,
  input  logic         mem_wr_ic_en,
  input  logic         w_complete,
  output logic         ic_en,
  output logic         l2_rdy,
  output logic [127:0] data_wd_l2,
  output logic         mem_req,
  output logic [31:0]  mem_addr,
  input  logic         mem_ack,
  input  logic [31:0]  mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state;
  logic [27:0]    req_line;
  logic [1:0]     beat;
  logic [1:0]     next_beat;
  logic           stale;
  logic           from_mem;
  logic           buf_valid;
  logic [27:0]    buf_line;
  logic [127:0]   buf_data;
  logic           hit;
  logic           buf_load;

  // Outputs are pure decodes of the registered state, so irq never reaches mem_req combinationally.
  assign ic_en   = (state != IDLE);
  assign l2_rdy  = (state == DONE);
  assign mem_req = (state == FETCH);

  // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    next_beat = beat + 2'd1;
    hit       = BUF_EN && buf_valid && (l2_addr == buf_line);
    // A store seen on the release edge itself also makes the line stale.
    buf_load  = BUF_EN && (state == DONE) && w_complete && from_mem
                && !stale && !mem_wr_ic_en;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_line   <= '0;
      beat       <= '0;
      stale      <= 1'b0;
      from_mem   <= 1'b0;
      buf_valid  <= 1'b0;
      mem_addr   <= '0;
      data_wd_l2 <= '0;
    end else begin
      // Invalidation wins over a coincident buffer load.
      if (mem_wr_ic_en) begin
        buf_valid <= 1'b0;
      end else if (buf_load) begin
        buf_valid <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (irq) begin
            req_line <= l2_addr;
            stale    <= mem_wr_ic_en;
            if (hit) begin
              data_wd_l2 <= buf_data;
              from_mem   <= 1'b0;
              state      <= DONE;
            end else begin
              beat     <= 2'd0;
              from_mem <= 1'b1;
              mem_addr <= {l2_addr, 2'b00, 2'b00};
              state    <= FETCH;
            end
          end
        end

        FETCH: begin
          if (mem_wr_ic_en) begin
            stale <= 1'b1;
          end
          if (mem_ack) begin
            data_wd_l2[{beat, 5'd0} +: 32] <= mem_rdata;
            beat     <= next_beat;
            mem_addr <= {req_line, next_beat, 2'b00};
            if (beat == 2'd3) begin
              state <= DONE;
            end
          end
        end

        DONE: begin
          if (mem_wr_ic_en) begin
            stale <= 1'b1;
          end
          if (w_complete) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: buffer contents are storage qualified by buf_valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (buf_load) begin
      buf_line <= req_line;
      buf_data <= data_wd_l2;
    end
  end

endmodule

// File: tb/tb_ic_refill_ctrl.sv
// Directed self-checking bench for ic_refill_ctrl: cold fill, wait states, buffer hit,
// invalidation, reset mid-fill and ignored requester signals.
module tb_ic_refill_ctrl;

  logic         clk;
  logic         reset;
  logic         irq;
  logic [27:0]  l2_addr;
  logic         mem_wr_ic_en;
  logic         w_complete;
  logic         ic_en;
  logic         l2_rdy;
  logic [127:0] data_wd_l2;
  logic         mem_req;
  logic [31:0]  mem_addr;
  logic         mem_ack;
  logic [31:0]  mem_rdata;

  int passed = 0;
  int total  = 0;

  localparam logic [127:0] LINE_A = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] LINE_B = 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001;
  localparam logic [127:0] LINE_C = 128'h0BADF00D_CAFEBABE_12345678_DEADBEEF;
  localparam logic [127:0] LINE_D = 128'h76543210_FEDCBA98_89ABCDEF_01234567;

  ic_refill_ctrl #(.BUF_EN(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .irq          (irq),
    .l2_addr      (l2_addr),
    .mem_wr_ic_en (mem_wr_ic_en),
    .w_complete   (w_complete),
    .ic_en        (ic_en),
    .l2_rdy       (l2_rdy),
    .data_wd_l2   (data_wd_l2),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs set afterwards are sampled on the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full memory fill of one line with a fixed number of wait cycles per beat.
  task automatic do_fill(input string name, input logic [27:0] line, input int waits,
                         input logic [127:0] line_data, input bit inval_b2, input bit stray);
    int lat;
    logic [1:0] bb;
    logic [31:0] want_addr;
    irq     = 1'b1;
    l2_addr = line;
    step();
    lat = 1;
    total++;
    if (mem_req !== 1'b1) $display("FAIL %s mem_req_start: got %b want 1", name, mem_req);
    else passed++;
    for (int b = 0; b < 4; b++) begin
      bb = b[1:0];
      want_addr = {line, bb, 2'b00};
      for (int w = 0; w < waits; w++) begin
        mem_ack      = 1'b0;
        mem_wr_ic_en = (inval_b2 && b == 2 && w == 0);
        if (stray && b == 1 && w == 0) begin
          w_complete = 1'b1;
          irq        = 1'b0;
          l2_addr    = 28'hFFFFFFF;
        end else if (stray && b == 1) begin
          w_complete = 1'b0;
          irq        = 1'b1;
        end
        total++;
        if (mem_addr !== want_addr || mem_req !== 1'b1)
          $display("FAIL %s wait_addr b%0d w%0d: got %h req %b want %h req 1",
                   name, b, w, mem_addr, mem_req, want_addr);
        else passed++;
        step();
        lat++;
      end
      w_complete   = 1'b0;
      mem_ack      = 1'b1;
      mem_rdata    = line_data[b*32 +: 32];
      mem_wr_ic_en = (inval_b2 && b == 2 && waits == 0);
      total++;
      if (mem_addr !== want_addr || l2_rdy !== 1'b0)
        $display("FAIL %s beat_addr b%0d: got %h rdy %b want %h rdy 0",
                 name, b, mem_addr, l2_rdy, want_addr);
      else passed++;
      step();
      lat++;
    end
    mem_ack      = 1'b0;
    mem_wr_ic_en = 1'b0;
    total++;
    if (l2_rdy !== 1'b1 || lat != 5 + 4 * waits)
      $display("FAIL %s l2_rdy_latency: got rdy %b at %0d want 1 at %0d",
               name, l2_rdy, lat, 5 + 4 * waits);
    else passed++;
    total++;
    if (data_wd_l2 !== line_data)
      $display("FAIL %s line_data: got %h want %h", name, data_wd_l2, line_data);
    else passed++;
  endtask

  task automatic release_line(input string name);
    w_complete = 1'b1;
    irq        = 1'b0;
    step();
    w_complete = 1'b0;
    total++;
    if (ic_en !== 1'b0 || l2_rdy !== 1'b0)
      $display("FAIL %s release: got ic_en %b l2_rdy %b want 0 0", name, ic_en, l2_rdy);
    else passed++;
  endtask

  task automatic expect_hit(input string name, input logic [27:0] line,
                            input logic [127:0] line_data);
    irq     = 1'b1;
    l2_addr = line;
    step();
    total++;
    if (l2_rdy !== 1'b1 || mem_req !== 1'b0)
      $display("FAIL %s hit_timing: got l2_rdy %b mem_req %b want 1 0", name, l2_rdy, mem_req);
    else passed++;
    total++;
    if (data_wd_l2 !== line_data)
      $display("FAIL %s hit_data: got %h want %h", name, data_wd_l2, line_data);
    else passed++;
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if (ic_en !== 1'b0 || l2_rdy !== 1'b0 || mem_req !== 1'b0)
      $display("FAIL %s ctrl: got ic_en %b l2_rdy %b mem_req %b want 0 0 0",
               name, ic_en, l2_rdy, mem_req);
    else passed++;
    total++;
    if (mem_addr !== 32'h0)
      $display("FAIL %s mem_addr: got %h want 00000000", name, mem_addr);
    else passed++;
    total++;
    if (data_wd_l2 !== 128'h0)
      $display("FAIL %s data_wd_l2: got %h want 0", name, data_wd_l2);
    else passed++;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    irq          = 1'b0;
    l2_addr      = '0;
    mem_wr_ic_en = 1'b0;
    w_complete   = 1'b0;
    mem_ack      = 1'b0;
    mem_rdata    = '0;
    step();
    step();
    reset = 1'b0;
    check_all_zero("reset");
  endtask

  task automatic test_cold_fill();
    do_fill("cold", 28'h0000123, 0, LINE_A, 1'b0, 1'b0);
    release_line("cold");
  endtask

  task automatic test_buffer_hit();
    expect_hit("hit", 28'h0000123, LINE_A);
    step();
    total++;
    if (l2_rdy !== 1'b1 || mem_req !== 1'b0 || data_wd_l2 !== LINE_A)
      $display("FAIL hit_hold: got l2_rdy %b mem_req %b data %h want 1 0 %h",
               l2_rdy, mem_req, data_wd_l2, LINE_A);
    else passed++;
    release_line("hit");
  endtask

  task automatic test_wait_states();
    mem_wr_ic_en = 1'b1;
    step();
    mem_wr_ic_en = 1'b0;
    do_fill("wait", 28'h0000123, 2, LINE_A, 1'b0, 1'b0);
    release_line("wait");
  endtask

  task automatic test_ignored_signals();
    w_complete = 1'b1;
    step();
    w_complete = 1'b0;
    total++;
    if (ic_en !== 1'b0 || l2_rdy !== 1'b0 || mem_req !== 1'b0)
      $display("FAIL stray_idle: got ic_en %b l2_rdy %b mem_req %b want 0 0 0",
               ic_en, l2_rdy, mem_req);
    else passed++;
    do_fill("stray", 28'h0000ABC, 2, LINE_C, 1'b0, 1'b1);
    release_line("stray");
  endtask

  task automatic test_invalidation();
    do_fill("inval1", 28'h0000456, 0, LINE_B, 1'b1, 1'b0);
    release_line("inval1");
    do_fill("inval2", 28'h0000456, 0, LINE_D, 1'b0, 1'b0);
    release_line("inval2");
    expect_hit("inval3", 28'h0000456, LINE_D);
    release_line("inval3");
  endtask

  task automatic test_reset_mid_fill();
    irq     = 1'b1;
    l2_addr = 28'h0000789;
    step();
    mem_ack   = 1'b1;
    mem_rdata = 32'h5555AAAA;
    step();
    mem_rdata = 32'h6666BBBB;
    step();
    mem_ack = 1'b0;
    reset   = 1'b1;
    step();
    reset = 1'b0;
    irq   = 1'b0;
    check_all_zero("rst_mid");
    do_fill("rst_refetch", 28'h0000456, 0, LINE_B, 1'b0, 1'b0);
    release_line("rst_refetch");
  endtask

  initial begin
    test_reset();
    test_cold_fill();
    test_buffer_hit();
    test_wait_states();
    test_ignored_signals();
    test_invalidation();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ic_refill_ctrl.md
# ic_refill_ctrl

Instruction-cache refill engine that sits directly upstream of the fetch stage's L2 port. It accepts a line-miss request from the icache controller, fetches the 128-bit line from main memory as four 32-bit beats, and returns the assembled line. A single-line reuse buffer answers a repeated miss to the most recently filled line without a memory access. Data-side writes into instruction memory (`mem_wr_ic_en`) invalidate that buffer.

## Interface
Parameters:
- `BUF_EN`, default 1: enables the reuse buffer. When 0, every request goes to memory.

Ports:
- `clk` in 1: clock. One clock domain.
- `reset` in 1: synchronous, active-high reset.
- `irq` in 1: icache line request (miss).
- `l2_addr` in 28: requested line address, byte address [31:4].
- `mem_wr_ic_en` in 1: a data-side store hit instruction memory; invalidates the reuse buffer.
- `w_complete` in 1: icache has written the returned line into L1.
- `ic_en` out 1: busy; a request is accepted and in progress.
- `l2_rdy` out 1: `data_wd_l2` is valid.
- `data_wd_l2` out 128: returned line. Word i occupies bits [32i+31:32i].
- `mem_req` out 1: memory read request.
- `mem_addr` out 32: word address, `{line, beat[1:0], 2'b00}`.
- `mem_ack` in 1: beat accepted; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: memory read data.

## Operation
- FSM states: IDLE, FETCH, DONE.
- **IDLE**
  - `ic_en`=0, `l2_rdy`=0, `mem_req`=0.
  - On `irq`=1, capture `l2_addr` into `req_line`.
  - If `BUF_EN` && `buf_valid` && `l2_addr`==`buf_line`, load the line from the buffer and go to DONE.
  - Otherwise clear the 2-bit beat counter and go to FETCH.
- **FETCH**
  - `ic_en`=1, `mem_req`=1, `mem_addr`={`req_line`, beat, 2'b00}.
  - On `mem_ack`, write `mem_rdata` into the line slot for the current beat and increment beat.
  - On the ack of beat 3, go to DONE. The counter wraps 3 to 0; the wrap is not used.
  - `mem_req` stays high between beats. There are no gaps imposed by this block.
- **DONE**
  - `ic_en`=1, `l2_rdy`=1, `data_wd_l2` held stable.
  - On `w_complete`, go to IDLE.
  - If the line came from memory, on that same edge load `buf_line`=`req_line` and `buf_valid`=1, unless the line is marked stale.
- **Stale flag**
  - Set if `mem_wr_ic_en` is seen on any cycle from acceptance through the cycle of `w_complete`.
  - Cleared on each acceptance.
- **Invalidation**
  - `mem_wr_ic_en` clears `buf_valid` in any state.
  - If it coincides with a buffer load, invalidation wins.
  - The line currently being delivered is still delivered. The requester owns the correctness of that line.
- **Requester rules**
  - Holds `irq` until it has seen `l2_rdy` and pulsed `w_complete`.
  - `irq` in FETCH or DONE is ignored, since the address was already captured.
  - `w_complete` outside DONE is ignored.
- **Reset mid-operation** (any state)
  - Next state IDLE; `buf_valid`=0, stale=0, beat=0.
  - An in-flight memory beat is abandoned. The memory side must tolerate `mem_req` dropping before `mem_ack`.

## Timing
- Reset values:
  - `ic_en`=0, `l2_rdy`=0, `mem_req`=0, `mem_addr`=0, `data_wd_l2`=0.
  - State IDLE; `buf_valid`=0.
- All outputs are registered or are decodes of registered state. There is no combinational path from `irq` to `mem_req`.
- Memory fill, with `irq` seen at edge N:
  - `mem_req` is high from cycle N+1.
  - With zero-wait memory (ack every cycle), beats complete at N+1..N+4.
  - `l2_rdy` is high from N+5.
  - Latency from `irq` to `l2_rdy` = 5 + total memory wait cycles.
- Buffer hit: `l2_rdy` is high at N+1, so latency = 1 cycle. `mem_req` never asserts.
- Release: `w_complete` at edge M drops `ic_en` and `l2_rdy` at M+1. A new `irq` is accepted at M+1 at the earliest.
- Back-to-back same-line miss: the request at M+1 hits the buffer, and `l2_rdy` is high at M+2.

## Test plan
- **Cold fill:** reset, then `irq`, `l2_addr`=28'h0000123, zero-wait memory returning 11111111, 22222222, 33333333, 44444444.
  - Required: `mem_addr` reads 00001230, 00001234, 00001238, 0000123C.
  - Required: `data_wd_l2`=128'h44444444_33333333_22222222_11111111 with `l2_rdy` at cycle 5.
- **Wait states:** same fill with `mem_ack` delayed 2 cycles per beat.
  - Required: `l2_rdy` at cycle 13; `mem_addr` is stable while waiting.
- **Buffer hit:** repeat the request for 0000123 after `w_complete`.
  - Required: `l2_rdy` 1 cycle after `irq`, `mem_req` stays 0, and the data is identical.
- **Invalidation:** pulse `mem_wr_ic_en` during beat 2 of a fill to line 0000456, then re-request 0000456.
  - Required: the first fill is delivered.
  - Required: the second request performs a full 4-beat memory fetch.
- **Reset mid-fill:** assert `reset` after beat 1.
  - Required: all outputs 0 the next cycle.
  - Required: a subsequent request to the previously buffered line goes to memory.
- **Ignored signals:** stray `w_complete` in IDLE and FETCH, and `irq` toggling in FETCH.
  - Required: no state change; the captured address is unchanged.
